ad100_fetch: RTL and testbench

Instruction fetch unit for the ad100 RV32 core. Sits directly upstream of the CPU decode stage and issues in-order word reads to instruction memory. Returned words are buffered with their PCs in a small prefetch FIFO, which feeds decode through a valid/ready handshake. It accepts redirects (branch, jump, trap) from execute, flushes buffered and in-flight fetches, and restarts at the new target.

---
 rtl/ad100_pkg.sv | 15 +
 rtl/ad100_fetch_fifo.sv | 56 +++++
 rtl/ad100_fetch.sv | 134 +++++++++++++
 tb/tb_ad100_fetch.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad100_pkg.sv
// ad100 shared types and constants.
// XLEN, default reset PC, fetch buffer entry.
package ad100_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] AD100_RESET_PC =
    32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ad100_fetch_fifo.sv
// ad100 fetch: small synchronous FIFO with flush.
// Flush wins over push and pop in the same cycle.
module ad100_fetch_fifo
  import ad100_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  T                             wdata,
  output T                             rdata,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T              mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wen;
  logic          ren;

  assign wen = push & ~flush;
  assign ren = pop & ~flush & (count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= rptr;
      count <= '0;
    end else begin
      if (wen) wptr <= wptr + AW'(1);
      if (ren) rptr <= rptr + AW'(1);
      count <= count + CW'(wen) - CW'(ren);
    end
  end

  always_ff @(posedge clk) begin
    if (wen) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(wen && count == CW'(DEPTH)));

endmodule

// File: rtl/ad100_fetch.sv
// ad100 instruction fetch with prefetch FIFO and redirect.
// Optional FETCH_MISALIGN_EN adds misalign_fault.
module ad100_fetch
  import ad100_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = AD100_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-3:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_MISALIGN_EN
  ,
  output logic            misalign_fault
`endif
);

  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [CW-1:0]   qcount;
  logic [CW:0]     used;
  logic            grant;
  logic            drop;
  logic            push;
  logic            pop;
  logic            fault;
  logic [XLEN-1:0] qpc;
  fetch_entry_t    wentry;
  fetch_entry_t    head;

`ifdef FETCH_MISALIGN_EN
  logic fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (redirect_valid) begin
      fault_q <= redirect_pc[1:0] != 2'b00;
    end
  end

  assign fault          = fault_q;
  assign misalign_fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // credit uses registered state only
  assign used = {1'b0, count} + {1'b0, outstanding};

  assign imem_req = ~reset & ~redirect_valid & ~fault &
                    (used < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc[XLEN-1:2];

  assign grant = imem_req & imem_gnt;
  assign drop  = imem_rvalid & (discard != '0);
  assign push  = imem_rvalid & ~drop;

  assign inst_valid = count != '0;
  assign pop        = inst_valid & inst_ready;
  assign inst_data  = inst_valid ? head.inst : '0;
  assign inst_pc    = inst_valid ? head.pc : '0;

  assign wentry = '{pc: qpc, inst: imem_rdata};

  assign outstanding_nxt = outstanding + CW'(grant) -
                           CW'(imem_rvalid);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~XLEN'(3);
        discard  <= outstanding_nxt;
      end else begin
        if (grant) fetch_pc <= fetch_pc + XLEN'(4);
        if (drop)  discard  <= discard - CW'(1);
      end
    end
  end

  ad100_fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wentry),
    .rdata (head),
    .count (count)
  );

  // tags in-flight requests; never flushed, stale tags pop on return
  ad100_fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (logic [XLEN-1:0])
  ) u_pcq (
    .clk   (clk),
    .reset (reset),
    .push  (grant),
    .pop   (imem_rvalid),
    .flush (1'b0),
    .wdata (fetch_pc),
    .rdata (qpc),
    .count (qcount)
  );

  a_tags_match: assert property (
    @(posedge clk) disable iff (reset)
    qcount == outstanding);

endmodule

// File: tb/tb_ad100_fetch.sv
// Bench for ad100_fetch: directed steps plus random traffic.
// Memory and expected stream are modelled in the bench.
module tb_ad100_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_EN
  logic        misalign_fault;
`endif

  ad100_fetch #(
    .RESET_PC (RPC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_EN
    ,
    .misalign_fault (misalign_fault)
`endif
  );

  typedef struct {
    logic [29:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  logic [29:0] gaddr[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          gnt_pct = 100;
  int          checks = 0;
  int          errors = 0;
  int          npop = 0;
  logic [31:0] exp_next = RPC;
  logic        hold = 0;
  logic [31:0] hold_pc;
  logic [31:0] hold_data;

  function automatic logic [31:0] memf(input logic [31:0] pc);
    return 32'h0000_0013 | (pc << 20);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // in-order memory: grant at random, data lat cycles later
  always begin
    @(posedge clk);
    #1;
    imem_gnt = $urandom_range(99) < gnt_pct;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf({pend[0].addr, 2'b00});
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  end

  // monitor: expected stream is contiguous from last target
  always @(negedge clk) begin
    if (reset) begin
      pend.delete();
      gaddr.delete();
      last_due = 0;
      exp_next = RPC;
      hold     = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 32'(inst_valid), 32'd1);
        chk("hold_pc", inst_pc, hold_pc);
        chk("hold_data", inst_data, hold_data);
      end
      if (redirect_valid)
        chk("redir_noreq", 32'(imem_req), 32'd0);
      if (imem_req)
        chk("credit", 32'(pend.size() < DEPTH), 32'd1);
      if (inst_valid && inst_ready && !redirect_valid) begin
        chk("pop_pc", inst_pc, exp_next);
        chk("pop_data", inst_data, memf(exp_next));
        exp_next = exp_next + 32'd4;
        npop++;
      end
      if (redirect_valid)
        exp_next = redirect_pc & ~32'd3;
      if (imem_rvalid && pend.size() != 0)
        void'(pend.pop_front());
      if (imem_req && imem_gnt) begin
        automatic int d;
        d = cyc + $urandom_range(lat_max, lat_min);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        pend.push_back('{addr: imem_addr, due: d});
        gaddr.push_back(imem_addr);
      end
      hold      = inst_valid && !inst_ready && !redirect_valid;
      hold_pc   = inst_pc;
      hold_data = inst_data;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // leaves the bench driving cycle 0 (first with reset low)
  task automatic do_reset();
    nxt();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    look();
    nxt();
    look();
    nxt();
    look();
    nxt();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int gs;
    reset          = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;

    // reset state
    do_reset();
    reset = 1'b1;
    look();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
`ifdef FETCH_MISALIGN_EN
    chk("rst_fault", 32'(misalign_fault), 32'd0);
`endif

    // zero-wait start-up
    inst_ready = 1'b1;
    do_reset();
    look();
    chk("c0_req", 32'(imem_req), 32'd1);
    chk("c0_addr", 32'(imem_addr), 32'd0);
    nxt();
    look();
    chk("c1_req", 32'(imem_req), 32'd1);
    chk("c1_addr", 32'(imem_addr), 32'd1);
    chk("c1_valid", 32'(inst_valid), 32'd0);
    nxt();
    look();
    chk("c2_credit_req", 32'(imem_req), 32'd0);
    chk("c2_valid", 32'(inst_valid), 32'd1);
    chk("c2_pc", inst_pc, 32'h0);
    chk("c2_data", inst_data, memf(32'h0));
    repeat (20) begin
      nxt();
      look();
    end
    chk("c_stream", 32'(npop > 8), 32'd1);

    // backpressure for six cycles
    inst_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) nxt();
      look();
      chk("bp_req", 32'(imem_req), 32'(i < 2));
      if (i >= 2) chk("bp_head", inst_pc, 32'h0);
    end
    chk("bp_grants", 32'(gaddr.size()), 32'd2);
    nxt();
    inst_ready = 1'b1;
    look();
    chk("bp_rel0", inst_pc, 32'h0);
    nxt();
    look();
    chk("bp_rel1_valid", 32'(inst_valid), 32'd1);
    chk("bp_rel1", inst_pc, 32'h4);
    repeat (10) begin
      nxt();
      look();
    end

    // redirect with two requests in flight, latency 3
    lat_min = 3;
    lat_max = 3;
    do_reset();
    look();
    nxt();
    look();
    nxt();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    look();
    chk("r3_req", 32'(imem_req), 32'd0);
    gs = gaddr.size();
    chk("r3_inflight", 32'(gs), 32'd2);
    nxt();
    redirect_valid = 1'b0;
    look();
    n = 0;
    while (gaddr.size() <= gs && n < 20) begin
      nxt();
      look();
      n++;
    end
    chk("r3_req_timeout", 32'(gaddr.size() > gs), 32'd1);
    if (gaddr.size() > gs)
      chk("r3_addr", 32'(gaddr[gs]), 32'h40);
    n = 0;
    while (!inst_valid && n < 20) begin
      nxt();
      look();
      n++;
    end
    chk("r3_valid_timeout", 32'(inst_valid), 32'd1);
    chk("r3_pc", inst_pc, 32'h100);
    chk("r3_data", inst_data, memf(32'h100));

    // redirect colliding with pop and return
    lat_min = 1;
    lat_max = 1;
    do_reset();
    look();
    nxt();
    look();
    nxt();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    look();
    chk("r4_pre_valid", 32'(inst_valid), 32'd1);
    chk("r4_pre_rv", 32'(imem_rvalid), 32'd1);
    nxt();
    redirect_valid = 1'b0;
    look();
    chk("r4_empty", 32'(inst_valid), 32'd0);
    chk("r4_req", 32'(imem_req), 32'd1);
    chk("r4_addr", 32'(imem_addr), 32'hC0);
    nxt();
    look();
    chk("r4_n2_valid", 32'(inst_valid), 32'd0);
    nxt();
    look();
    chk("r4_n3_valid", 32'(inst_valid), 32'd1);
    chk("r4_n3_pc", inst_pc, 32'h300);

    // address wrap
    nxt();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    look();
    gs = gaddr.size();
    nxt();
    redirect_valid = 1'b0;
    look();
    n = 0;
    while (gaddr.size() < gs + 3 && n < 30) begin
      nxt();
      look();
      n++;
    end
    chk("wrap_timeout", 32'(gaddr.size() >= gs + 3), 32'd1);
    if (gaddr.size() >= gs + 3) begin
      chk("wrap_a0", 32'(gaddr[gs]), 32'h3FFF_FFFE);
      chk("wrap_a1", 32'(gaddr[gs+1]), 32'h3FFF_FFFF);
      chk("wrap_a2", 32'(gaddr[gs+2]), 32'h0);
    end
    repeat (5) begin
      nxt();
      look();
    end

    // random traffic, redirects and backpressure
    lat_min = 1;
    lat_max = 4;
    gnt_pct = 60;
    npop    = 0;
    for (int i = 0; i < 2000; i++) begin
      nxt();
      inst_ready     = $urandom_range(99) < 70;
      redirect_valid = $urandom_range(99) < 3;
      redirect_pc    = ($urandom_range(3) == 0) ?
                       32'hFFFF_FFF0 : ($urandom & ~32'd3);
      look();
    end
    nxt();
    redirect_valid = 1'b0;
    look();
    chk("rand_progress", 32'(npop > 50), 32'd1);

`ifdef FETCH_MISALIGN_EN
    lat_min    = 1;
    lat_max    = 1;
    gnt_pct    = 100;
    inst_ready = 1'b1;
    do_reset();
    look();
    repeat (3) begin
      nxt();
      look();
    end
    nxt();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    look();
    nxt();
    redirect_valid = 1'b0;
    look();
    chk("mis_fault", 32'(misalign_fault), 32'd1);
    chk("mis_req", 32'(imem_req), 32'd0);
    repeat (4) begin
      nxt();
      look();
      chk("mis_hold_req", 32'(imem_req), 32'd0);
      chk("mis_empty", 32'(inst_valid), 32'd0);
    end
    nxt();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    look();
    chk("mis_fault_held", 32'(misalign_fault), 32'd1);
    nxt();
    redirect_valid = 1'b0;
    look();
    chk("mis_clear", 32'(misalign_fault), 32'd0);
    chk("mis_resume", 32'(imem_req), 32'd1);
    chk("mis_addr", 32'(imem_addr), 32'h80);
    n = 0;
    while (!inst_valid && n < 20) begin
      nxt();
      look();
      n++;
    end
    chk("mis_valid", 32'(inst_valid), 32'd1);
    chk("mis_pc", inst_pc, 32'h200);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
